// File: rtl/unum4_pkg.sv
// Shared constants and helpers for the unum4 datapath: reserved exponents,
// special-word construction and exponent/fraction width derivation.
package unum4_pkg;

  localparam int U4_DATA_W    = 32;
  localparam int U4_MAN_MAX_W = 29;
  localparam int U4_EXP_SZ_W  = 4;
  localparam int U4_EXP_MAX_W = 16;
  localparam int U4_FRAC_W    = U4_MAN_MAX_W - 2;
  localparam int U4_EW_W      = $clog2(U4_EXP_MAX_W + 1);
  localparam int U4_K_BASE    = U4_DATA_W - U4_EXP_SZ_W - 1;
  localparam int U4_TAIL_W    = U4_DATA_W - U4_EXP_SZ_W - U4_EXP_MAX_W - 1;

  localparam logic [U4_EXP_MAX_W-1:0] EXP_ZERO   = {1'b1, {(U4_EXP_MAX_W-1){1'b0}}};
  localparam logic [U4_EXP_MAX_W-1:0] EXP_NAR    = {1'b1, {(U4_EXP_MAX_W-2){1'b0}}, 1'b1};
  localparam logic [U4_EXP_MAX_W-1:0] EXP_MIN    = {1'b1, {(U4_EXP_MAX_W-3){1'b0}}, 2'b10};
  localparam logic [U4_EXP_MAX_W-1:0] EXP_MAXPOS = {1'b0, {(U4_EXP_MAX_W-1){1'b1}}};

  typedef enum logic [1:0] {
    SPC_ZERO,
    SPC_NAR,
    SPC_SAT
  } spc_e;

  // Reserved and saturation words all use es = all ones (ew = EXP_MAX_W).
  function automatic logic [U4_DATA_W-1:0] special_word(input spc_e kind, input logic sign);
    case (kind)
      SPC_NAR: return {{U4_EXP_SZ_W{1'b1}}, EXP_NAR, 1'b1, {U4_TAIL_W{1'b0}}};
      SPC_SAT: return sign ? {{U4_EXP_SZ_W{1'b1}}, EXP_MAXPOS, 1'b1, {U4_TAIL_W{1'b0}}}
                           : {{U4_EXP_SZ_W{1'b1}}, EXP_MAXPOS, 1'b0, {U4_TAIL_W{1'b1}}};
      default: return {{U4_EXP_SZ_W{1'b1}}, EXP_ZERO, 1'b0, {U4_TAIL_W{1'b0}}};
    endcase
  endfunction

  function automatic logic [U4_EW_W-1:0] ew_from_rsb(input logic [U4_EW_W-1:0] rsb);
    return U4_EW_W'(U4_EXP_MAX_W) - rsb;
  endfunction

  function automatic logic [U4_EW_W-1:0] k_from_ew(input logic [U4_EW_W-1:0] ew);
    return U4_EW_W'(U4_K_BASE) - ew;
  endfunction

endpackage

// File: rtl/unum4_rsb.sv
// Combinational redundant-sign-bit counter; returns the minimum
// two's-complement width (ew) of a signed exponent.
module unum4_rsb
  import unum4_pkg::*;
(
  input  logic [U4_EXP_MAX_W-1:0] i_exp,
  output logic [U4_EW_W-1:0]      o_ew
);

  logic [U4_EW_W-1:0] w_rsb;
  logic               w_run;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    w_rsb = '0;
    w_run = 1'b1;
    for (int i = U4_EXP_MAX_W - 2; i >= 0; i--) begin
      if (w_run && (i_exp[i] == i_exp[U4_EXP_MAX_W-1])) w_rsb = w_rsb + U4_EW_W'(1);
      else                                              w_run = 1'b0;
    end
  end

  assign o_ew = ew_from_rsb(w_rsb);

endmodule

// File: rtl/unum4_pack.sv
// Three-stage unum4 result packer (register, round/normalize, assemble).
// Define UNUM4_PACK_SAT_EN to saturate on overflow instead of emitting NaR.
module unum4_pack
  import unum4_pkg::*;
#(
  parameter int DATA_W    = U4_DATA_W,
  parameter int MAN_MAX_W = U4_MAN_MAX_W,
  parameter int EXP_SZ_W  = U4_EXP_SZ_W,
  parameter int EXP_MAX_W = U4_EXP_MAX_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [MAN_MAX_W-1:0] m_i,
  input  logic [EXP_MAX_W-1:0] e_i,
  input  logic                 over_i,
  input  logic                 under_i,
  output logic [DATA_W-1:0]    data_o,
  output logic                 done,
  output logic                 over_o
);

  localparam int FRAC_W = MAN_MAX_W - 2;
  localparam int MX_W   = MAN_MAX_W + 1;
  localparam int TAIL_W = DATA_W - EXP_SZ_W;

`ifdef UNUM4_PACK_SAT_EN
  localparam spc_e OVF_KIND = SPC_SAT;
`else
  localparam spc_e OVF_KIND = SPC_NAR;
`endif

  logic                 r_s1_valid, r_s1_over, r_s1_under;
  logic [MAN_MAX_W-1:0] r_s1_man;
  logic [EXP_MAX_W-1:0] r_s1_exp;

  logic                 r_s2_valid, r_s2_over, r_s2_zero, r_s2_ovf, r_s2_unf, r_s2_sign;
  logic [EXP_MAX_W-1:0] r_s2_exp;
  logic [FRAC_W-1:0]    r_s2_frac;

  // ---------------------------------------------------------------- valid chain
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      r_s1_valid <= start;
      r_s2_valid <= r_s1_valid;
    end
  end

  // ---------------------------------------------------------------- S2: round and carry-normalize
  logic [U4_EW_W-1:0]   w_ew_pre, w_k, w_drop;
  logic [MX_W-1:0]      w_mx, w_ulp, w_low_mask, w_sum, w_rnd;
  logic                 w_guard, w_sticky, w_lsb, w_rnd_up;
  logic                 w_carry_pos, w_carry_neg, w_zero;
  logic [EXP_MAX_W-1:0] w_exp_fin;
  logic [FRAC_W-1:0]    w_frac;

  unum4_rsb u_rsb_pre (
    .i_exp (r_s1_exp),
    .o_ew  (w_ew_pre)
  );

  assign w_k    = k_from_ew(w_ew_pre);
  assign w_drop = U4_EW_W'(FRAC_W) - w_k;

  // Rounding adds one kept-LSB weight to the two's-complement value itself.
  assign w_mx       = {r_s1_man[MAN_MAX_W-1], r_s1_man};
  assign w_ulp      = MX_W'(1) << w_drop;
  assign w_low_mask = w_ulp - MX_W'(1);
  assign w_guard    = |(w_mx & (w_ulp >> 1));
  assign w_sticky   = |(w_mx & (w_low_mask >> 1));
  assign w_lsb      = |(w_mx & w_ulp);
  assign w_rnd_up   = w_guard & (w_sticky | w_lsb);
  assign w_sum      = w_mx + (w_rnd_up ? w_ulp : '0);
  assign w_rnd      = w_sum & ~w_low_mask;

  assign w_carry_pos = (w_rnd[MX_W-1:MX_W-3] == 3'b010);
  assign w_carry_neg = (w_rnd[MX_W-1:MX_W-3] == 3'b111);

  assign w_exp_fin = w_carry_pos ? r_s1_exp + EXP_MAX_W'(1) :
                     w_carry_neg ? r_s1_exp - EXP_MAX_W'(1) : r_s1_exp;
  assign w_frac    = (w_carry_pos | w_carry_neg) ? '0 : w_rnd[FRAC_W-1:0];
  assign w_zero    = r_s1_under | (r_s1_man == '0) | ($signed(r_s1_exp) <= $signed(EXP_NAR));

  // NOTE: datapath registers carry no reset; the valid bits alone decide whether they matter.
  always_ff @(posedge clk) begin
    if (start) begin
      r_s1_man   <= m_i;
      r_s1_exp   <= e_i;
      r_s1_over  <= over_i;
      r_s1_under <= under_i;
    end
    if (r_s1_valid) begin
      r_s2_over <= r_s1_over;
      r_s2_zero <= w_zero;
      r_s2_ovf  <= w_carry_pos & (r_s1_exp == EXP_MAXPOS);
      r_s2_unf  <= w_carry_neg & (r_s1_exp == EXP_MIN);
      r_s2_sign <= r_s1_man[MAN_MAX_W-1];
      r_s2_exp  <= w_exp_fin;
      r_s2_frac <= w_frac;
    end
  end

  // ---------------------------------------------------------------- S3: assemble and override
  logic [U4_EW_W-1:0]  w_ew_post;
  logic [EXP_SZ_W-1:0] w_es;
  logic [TAIL_W-1:0]   w_tail;
  logic [DATA_W-1:0]   w_norm, w_ovf_word, w_zero_word, w_word;
  logic                w_ovf;

  unum4_rsb u_rsb_post (
    .i_exp (r_s2_exp),
    .o_ew  (w_ew_post)
  );

  // Shifting right by ew leaves {exp[ew-1:0], sign, top k fraction bits} in the tail.
  assign w_es        = EXP_SZ_W'(w_ew_post - U4_EW_W'(1));
  assign w_tail      = TAIL_W'({r_s2_exp, r_s2_sign, r_s2_frac} >> w_ew_post);
  assign w_norm      = {w_es, w_tail};
  assign w_ovf_word  = special_word(OVF_KIND, r_s2_sign);
  assign w_zero_word = special_word(SPC_ZERO, 1'b0);

  always_comb begin
    w_word = w_norm;
    w_ovf  = 1'b0;
    if (r_s2_over) begin
      w_word = w_ovf_word;
      w_ovf  = 1'b1;
    end else if (r_s2_zero) begin
      w_word = w_zero_word;
    end else if (r_s2_ovf) begin
      w_word = w_ovf_word;
      w_ovf  = 1'b1;
    end else if (r_s2_unf) begin
      w_word = w_zero_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done   <= 1'b0;
      data_o <= '0;
      over_o <= 1'b0;
    end else begin
      done <= r_s2_valid;
      if (r_s2_valid) begin
        data_o <= w_word;
        over_o <= w_ovf;
      end
    end
  end

endmodule
